// File: rtl/mpu_thread_sender_if.sv
// Thread-store bundle between the sender, the host staging buffer and the thread memory.
// Store side: every cycle with O_Req_St=1 carries one word; the memory stalls the length header with I_Wait and releases the instruction stream with I_Ack_St.
interface mpu_thread_sender_if #(
  parameter int WIDTH_ADDR  = 10,
  parameter int WIDTH_INSTR = 32,
  parameter int WIDTH_ID    = 8
);
  logic                   I_Start;
  logic [WIDTH_ID-1:0]    I_ThreadID;
  logic [WIDTH_ADDR:0]    I_Length;
  logic                   O_Src_Re;
  logic [WIDTH_ADDR-1:0]  O_Src_Addr;
  logic [WIDTH_INSTR-1:0] I_Src_Instr;
  logic                   O_Req_St;
  logic [WIDTH_INSTR-1:0] O_Instr_St;
  logic                   I_Wait;
  logic                   I_Ack_St;
  logic                   O_Busy;
  logic                   O_Done;
  logic                   O_Err;

  modport master (
    input  I_Start, I_ThreadID, I_Length, I_Src_Instr, I_Wait, I_Ack_St,
    output O_Src_Re, O_Src_Addr, O_Req_St, O_Instr_St, O_Busy, O_Done, O_Err
  );

  modport slave (
    output I_Start, I_ThreadID, I_Length, I_Src_Instr, I_Wait, I_Ack_St,
    input  O_Src_Re, O_Src_Addr, O_Req_St, O_Instr_St, O_Busy, O_Done, O_Err
  );
endinterface

// File: rtl/mpu_thread_sender.sv
// Sends one thread program (length header, thread-ID, instruction stream) into the
// thread memory store port, reading instructions from a 1-cycle-latency staging buffer.
module mpu_thread_sender #(
  parameter int SIZE_THREAD_MEM = 1024,
  parameter int WIDTH_ADDR      = $clog2(SIZE_THREAD_MEM),
  parameter int WIDTH_INSTR     = 32,
  parameter int WIDTH_ID        = 8
) (
  input  logic                clock,
  input  logic                reset,
  mpu_thread_sender_if.master bus,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OPEN   = 3'd1,
    S_LEN    = 3'd2,
    S_SETUP  = 3'd3,
    S_ID     = 3'd4,
    S_LOOKUP = 3'd5,
    S_DATA   = 3'd6
  } state_t;

  localparam logic [WIDTH_ADDR:0]   LEN_MAX = (WIDTH_ADDR+1)'(SIZE_THREAD_MEM);
  localparam logic [WIDTH_ADDR:0]   LEN_ONE = (WIDTH_ADDR+1)'(1);
  localparam logic [WIDTH_ADDR-1:0] ADDR_1  = WIDTH_ADDR'(1);
  localparam logic [WIDTH_ADDR-1:0] ADDR_2  = WIDTH_ADDR'(2);

  state_t                 state_q;
  logic [WIDTH_ID-1:0]    id_q;
  logic [WIDTH_ADDR-1:0]  len_m1_q;
  logic [WIDTH_ADDR-1:0]  beat_q;
  logic                   len_min_q;
  logic                   req_q;
  logic [WIDTH_INSTR-1:0] word_q;
  logic                   src_re_q;
  logic [WIDTH_ADDR-1:0]  src_addr_q;
  logic                   done_q;
  logic                   err_q;

  logic                   len_ok;
  logic                   last_beat;
  logic                   next_reads;
  logic [WIDTH_ADDR-1:0]  beat_inc;

  assign len_ok     = (bus.I_Length != '0) && (bus.I_Length <= LEN_MAX);
  assign last_beat  = (beat_q == len_m1_q);
  assign beat_inc   = beat_q + ADDR_1;
  // The beat after this one still needs a follow-on read unless it is the last word.
  assign next_reads = (beat_inc != len_m1_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      id_q       <= '0;
      len_m1_q   <= '0;
      beat_q     <= '0;
      len_min_q  <= 1'b0;
      req_q      <= 1'b0;
      word_q     <= '0;
      src_re_q   <= 1'b0;
      src_addr_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.I_Start) begin
            if (len_ok) begin
              id_q       <= bus.I_ThreadID;
              len_m1_q   <= WIDTH_ADDR'(bus.I_Length - LEN_ONE);
              beat_q     <= '0;
              src_addr_q <= '0;
              req_q      <= 1'b1;
              word_q     <= '0;
              state_q    <= S_OPEN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_OPEN: begin
          word_q    <= WIDTH_INSTR'(len_m1_q);
          len_min_q <= 1'b0;
          state_q   <= S_LEN;
        end
        S_LEN: begin
          // First LEN cycle is unconditional so the receiver's size check has settled.
          len_min_q <= 1'b1;
          if (len_min_q && !bus.I_Wait) begin
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          word_q  <= WIDTH_INSTR'(id_q);
          state_q <= S_ID;
        end
        S_ID: begin
          src_re_q   <= 1'b1;
          src_addr_q <= '0;
          state_q    <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (bus.I_Ack_St) begin
            beat_q     <= '0;
            src_re_q   <= (len_m1_q != '0);
            src_addr_q <= ADDR_1;
            state_q    <= S_DATA;
          end
        end
        S_DATA: begin
          if (last_beat) begin
            req_q      <= 1'b0;
            word_q     <= '0;
            src_re_q   <= 1'b0;
            src_addr_q <= '0;
            done_q     <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            beat_q   <= beat_inc;
            src_re_q <= next_reads;
            // Address only advances while reads remain, so it tops out at depth-1.
            if (next_reads) begin
              src_addr_q <= beat_q + ADDR_2;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.O_Req_St   = req_q;
  assign bus.O_Instr_St = (state_q == S_DATA) ? bus.I_Src_Instr : word_q;
  assign bus.O_Src_Re   = src_re_q;
  assign bus.O_Src_Addr = src_addr_q;
  assign bus.O_Busy     = (state_q != S_IDLE);
  assign bus.O_Done     = done_q;
  assign bus.O_Err      = err_q;
  assign dbg_state_o    = state_q;

endmodule
